// File: rtl/hipass_rx_pkg.sv
// Shared types and constants for the Hi-Pass card receiver.
// Frame: start, DATA_BITS data LSB first, even parity, stop.
package hipass_rx_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_START  = 3'd1;
    localparam state_t ST_DATA   = 3'd2;
    localparam state_t ST_PARITY = 3'd3;
    localparam state_t ST_STOP   = 3'd4;

    localparam int DATA_BITS = 4;
    localparam int IDX_W     = 2;

    localparam logic [DATA_BITS-1:0] NO_CARD = 4'd0;

    // True when data plus parity bit carry an even number of ones.
    function automatic logic parity_even(input logic [DATA_BITS-1:0] d, input logic p);
        return ~(^{d, p});
    endfunction

endpackage

// File: rtl/hipass_rx_debounce.sv
// Level debouncer: dout follows din once din has differed for DEB_TICKS clocks.
// fall is a combinational flag, high in the cycle whose edge drops dout from 1 to 0.
module debounce #(
    parameter int DEB_TICKS = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout,
    output logic fall
);

    localparam int              CW       = $clog2(DEB_TICKS + 1);
    localparam logic [CW-1:0]   CNT_LAST = CW'(DEB_TICKS - 1);

    logic [CW-1:0] cnt;
    logic          flip;

    assign flip = (din != dout) && (cnt == CNT_LAST);
    assign fall = flip && dout;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt  <= '0;
            dout <= 1'b0;
        end else if (din == dout) begin
            cnt <= '0;
        end else if (flip) begin
            dout <= din;
            cnt  <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/hipass_rx.sv
// Hi-Pass card-reader receiver: debounced vehicle sensor plus 4-bit serial frame decoder.
// Latched code is valid only while a vehicle is present; cleared when the vehicle leaves.
module hipass_rx
    import hipass_rx_pkg::*;
#(
    parameter int BIT_TICKS = 16,
    parameter int DEB_TICKS = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 car_raw,
    input  logic                 rx,
    output logic                 car,
    output logic [DATA_BITS-1:0] hipass_out,
    output logic                 hipass_valid,
    output logic                 frame_err
);

    localparam int              TW        = $clog2(BIT_TICKS);
    localparam logic [TW-1:0]   TICK_LAST = TW'(BIT_TICKS - 1);
    localparam logic [TW-1:0]   TICK_HALF = TW'(BIT_TICKS / 2 - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

    logic [1:0]           car_sync;
    logic [1:0]           rx_sync;
    logic                 car_s;
    logic                 rx_s;
    logic [1:0]           sync_age;
    logic                 rx_prev;
    logic                 rx_fall;
    logic                 car_fall;

    state_t               state;
    logic [TW-1:0]        tick;
    logic [IDX_W-1:0]     bit_idx;
    logic [DATA_BITS-1:0] data;
    logic                 par;
    logic                 frame_ok;
    logic                 tick_last;

    always_ff @(posedge clk) begin
        if (rst) begin
            car_sync <= 2'b00;
            rx_sync  <= 2'b11;
        end else begin
            car_sync <= {car_sync[0], car_raw};
            rx_sync  <= {rx_sync[0], rx};
        end
    end

    assign car_s = car_sync[1];
    assign rx_s  = rx_sync[1];

    // The rx synchronizer holds its reset value for two clocks after reset; edge detection
    // ignores that window so a line already low at release never looks like a new start bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_age <= 2'd0;
            rx_prev  <= 1'b0;
        end else begin
            if (sync_age != 2'd2)
                sync_age <= sync_age + 2'd1;
            rx_prev <= (sync_age == 2'd2) ? rx_s : 1'b0;
        end
    end

    assign rx_fall = rx_prev && !rx_s;

    debounce #(
        .DEB_TICKS (DEB_TICKS)
    ) u_car_deb (
        .clk  (clk),
        .rst  (rst),
        .din  (car_s),
        .dout (car),
        .fall (car_fall)
    );

    assign frame_ok  = rx_s && parity_even(data, par) && (data != NO_CARD);
    assign tick_last = (tick == TICK_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            tick         <= '0;
            bit_idx      <= '0;
            data         <= '0;
            par          <= 1'b0;
            hipass_out   <= NO_CARD;
            hipass_valid <= 1'b0;
            frame_err    <= 1'b0;
        end else begin
            hipass_valid <= 1'b0;
            frame_err    <= 1'b0;
            if (car_fall)
                hipass_out <= NO_CARD;

            case (state)
                ST_IDLE: begin
                    if (rx_fall) begin
                        state <= ST_START;
                        tick  <= '0;
                    end
                end
                ST_START: begin
                    if (tick == TICK_HALF) begin
                        tick    <= '0;
                        bit_idx <= '0;
                        state   <= rx_s ? ST_IDLE : ST_DATA;
                    end else begin
                        tick <= tick + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (tick_last) begin
                        tick          <= '0;
                        data[bit_idx] <= rx_s;
                        bit_idx       <= bit_idx + 1'b1;
                        if (bit_idx == IDX_LAST)
                            state <= ST_PARITY;
                    end else begin
                        tick <= tick + 1'b1;
                    end
                end
                ST_PARITY: begin
                    if (tick_last) begin
                        tick  <= '0;
                        par   <= rx_s;
                        state <= ST_STOP;
                    end else begin
                        tick <= tick + 1'b1;
                    end
                end
                ST_STOP: begin
                    if (tick_last) begin
                        tick  <= '0;
                        state <= ST_IDLE;
                        // A vehicle leaving on this very edge takes priority over the new code.
                        if (!frame_ok) begin
                            frame_err <= 1'b1;
                        end else if (car && !car_fall) begin
                            hipass_out   <= data;
                            hipass_valid <= 1'b1;
                        end
                    end else begin
                        tick <= tick + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hipass_rx.sv
// Scoreboard bench for hipass_rx: directed scenarios plus randomized frames.
module tb_hipass_rx;

    localparam int BT  = 16;
    localparam int DEB = 8;

    typedef struct packed {
        logic       is_err;
        logic [3:0] code;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       car_raw;
    logic       rx;
    logic       car;
    logic [3:0] hipass_out;
    logic       hipass_valid;
    logic       frame_err;

    exp_t       exp_q[$];
    logic [3:0] model_out;
    int         n_checks;
    int         n_fail;

    hipass_rx #(
        .BIT_TICKS (BT),
        .DEB_TICKS (DEB)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .car_raw      (car_raw),
        .rx           (rx),
        .car          (car),
        .hipass_out   (hipass_out),
        .hipass_valid (hipass_valid),
        .frame_err    (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        rx = b;
        wait_clk(BT);
    endtask

    // Expected outcome comes straight from the frame rules; the pulse is matched by the monitor.
    task automatic send_frame(input logic [3:0] d, input logic p, input logic s, input logic car_on);
        exp_t e;
        if (!s || (^{d, p}) || d == 4'd0) begin
            e.is_err = 1'b1;
            e.code   = 4'd0;
            exp_q.push_back(e);
        end else if (car_on) begin
            e.is_err = 1'b0;
            e.code   = d;
            exp_q.push_back(e);
            model_out = d;
        end
        send_bit(1'b0);
        for (int i = 0; i < 4; i++)
            send_bit(d[i]);
        send_bit(p);
        send_bit(s);
        if (!s)
            wait_clk(BT / 2);
        rx = 1'b1;
        wait_clk(BT);
        check("pending_pulses", exp_q.size(), 0);
        check("hipass_out_after_frame", {28'd0, hipass_out}, {28'd0, model_out});
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (hipass_valid && frame_err)
                check("valid_err_exclusive", 1, 0);
            if (hipass_valid || frame_err) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_pulse", {30'd0, hipass_valid, frame_err}, 0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("pulse_kind", {31'd0, frame_err}, {31'd0, e.is_err});
                    if (!e.is_err)
                        check("pulse_code", {28'd0, hipass_out}, {28'd0, e.code});
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int         seen;
        int         found;
        logic [3:0] prev_out;
        logic [3:0] d;
        logic       p;
        logic       s;

        n_checks  = 0;
        n_fail    = 0;
        model_out = 4'd0;
        rst       = 1'b1;
        car_raw   = 1'b0;
        rx        = 1'b1;
        wait_clk(5);
        check("rst_car", {31'd0, car}, 0);
        check("rst_hipass_out", {28'd0, hipass_out}, 0);
        check("rst_valid", {31'd0, hipass_valid}, 0);
        check("rst_frame_err", {31'd0, frame_err}, 0);
        rst = 1'b0;
        wait_clk(4);

        // 7-clock glitch must be rejected, 8 stable clocks (plus 2 sync) must pass.
        car_raw = 1'b1;
        wait_clk(7);
        car_raw = 1'b0;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            wait_clk(1);
            if (car) seen++;
        end
        check("deb_short_pulse", seen, 0);
        car_raw = 1'b1;
        wait_clk(DEB + 1);
        check("deb_before_rise", {31'd0, car}, 0);
        wait_clk(1);
        check("deb_rise", {31'd0, car}, 1);
        wait_clk(4);

        send_frame(4'h3, 1'b1, 1'b1, 1'b1);
        send_frame(4'hA, 1'b0, 1'b1, 1'b1);

        rx = 1'b0;
        wait_clk(3);
        rx = 1'b1;
        wait_clk(2 * BT);
        check("glitch_pending", exp_q.size(), 0);
        check("glitch_out", {28'd0, hipass_out}, 4'hA);

        send_frame(4'h5, 1'b0, 1'b1, 1'b1);

        // Car leaves: code must clear on exactly the cycle car drops.
        car_raw  = 1'b0;
        found    = 0;
        prev_out = hipass_out;
        for (int i = 0; i < 30; i++) begin
            wait_clk(1);
            if (!car) begin
                found = 1;
                break;
            end
            prev_out = hipass_out;
        end
        model_out = 4'd0;
        check("car_fall_seen", found, 1);
        check("car_fall_clear", {28'd0, hipass_out}, 0);
        check("car_fall_prev", {28'd0, prev_out}, 4'h5);

        send_frame(4'h6, 1'b0, 1'b1, 1'b0);
        send_frame(4'h7, 1'b0, 1'b1, 1'b0);

        car_raw = 1'b1;
        wait_clk(20);
        check("car_back", {31'd0, car}, 1);

        send_frame(4'hC, 1'b0, 1'b0, 1'b1);
        send_frame(4'h0, 1'b0, 1'b1, 1'b1);
        send_frame(4'hE, 1'b1, 1'b1, 1'b1);

        // Reset in the middle of data bit 2, line held low across the release.
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        rx = 1'b0;
        wait_clk(BT / 2);
        rst = 1'b1;
        wait_clk(3);
        check("midrst_out", {28'd0, hipass_out}, 0);
        check("midrst_car", {31'd0, car}, 0);
        rst       = 1'b0;
        model_out = 4'd0;
        wait_clk(BT);
        rx = 1'b1;
        wait_clk(2 * BT);
        check("midrst_pending", exp_q.size(), 0);
        check("midrst_car_back", {31'd0, car}, 1);
        send_frame(4'h9, 1'b0, 1'b1, 1'b1);

        for (int n = 0; n < 30; n++) begin
            d = 4'($urandom_range(0, 15));
            p = ($urandom_range(0, 3) == 0) ? ~(^d) : (^d);
            s = ($urandom_range(0, 7) != 0);
            send_frame(d, p, s, 1'b1);
        end

        wait_clk(BT);
        check("queue_empty_end", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/hipass_rx.md
HIPASS_RX -- requirements
Module: hipass_rx

Interface
REQ-001 Parameter BIT_TICKS, default 16: clocks per serial bit, even, 4 to 256.
REQ-002 Parameter DEB_TICKS, default 8: consecutive stable clocks required to accept a car-sensor change.
REQ-003 The block SHALL use one clock and one synchronous, active-high reset.
REQ-004 Port clk, input, 1: system clock, rising edge.
REQ-005 Port rst, input, 1: synchronous active-high reset.
REQ-006 Port car_raw, input, 1: asynchronous loop-sensor level, 1 = vehicle present.
REQ-007 Port rx, input, 1: asynchronous serial line from the card reader, idle high.
REQ-008 Port car, output, 1: debounced vehicle-present level for the toll stage.
REQ-009 Port hipass_out, output, 4: latched card code; 0 = no card.
REQ-010 Port hipass_valid, output, 1: one-cycle pulse when hipass_out takes a new nonzero code.
REQ-011 Port frame_err, output, 1: one-cycle pulse on a rejected frame.

Function
REQ-012 car_raw and rx SHALL each pass through a two-flop synchronizer before use; rx synchronizer flops reset to 1, car_raw flops reset to 0.
REQ-013 Debounce: the synchronized car level SHALL differ from car for DEB_TICKS consecutive clocks before car toggles; any mismatch-free cycle resets the stability count.
REQ-014 Frame format: start bit (0), 4 data bits LSB first, even parity bit (parity over data plus parity = 0), stop bit (1).
REQ-015 FSM states: IDLE, START, DATA, PARITY, STOP.
REQ-016 IDLE -> START on synchronized rx falling to 0; tick counter cleared.
REQ-017 START: at tick BIT_TICKS/2-1, rx=0 -> DATA with tick counter cleared; rx=1 -> IDLE (false start, no error pulse).
REQ-018 DATA, PARITY, STOP: sample rx when the tick counter reaches BIT_TICKS-1, i.e. at mid-bit; DATA advances after the 4th sample, using a 2-bit index.
REQ-019 STOP sample: the frame SHALL be accepted only if stop=1, parity is even, data != 0, and car=1; the FSM then returns to IDLE.
REQ-020 Accepted frame: hipass_out <= data and hipass_valid=1 in the cycle after the stop sample.
REQ-021 Rejected frame (stop=0, parity odd, or data=0): frame_err=1 in the cycle after the stop sample; hipass_out unchanged.
REQ-022 A well-formed frame received while car=0 SHALL be discarded silently, with no valid and no error pulse.
REQ-023 On a stop=0 framing error, the FSM SHALL wait in IDLE for rx=1 before it re-arms on a falling edge.
REQ-024 A new accepted frame while hipass_out is nonzero SHALL overwrite it and pulse hipass_valid again.
REQ-025 When car falls from 1 to 0, hipass_out SHALL clear to 0 in the same cycle car updates.
REQ-026 If a car fall and an accepted frame coincide, the clear SHALL win: hipass_out=0 and no hipass_valid.
REQ-027 hipass_valid and frame_err SHALL never assert in the same cycle.

Reset
REQ-028 Reset values: car=0, hipass_out=0, hipass_valid=0, frame_err=0, FSM=IDLE, all counters 0.
REQ-029 Reset asserted mid-frame SHALL abort the frame with no pulse; reception resumes only on a fresh falling edge after reset is released.

Structure
REQ-030 Package hipass_rx_pkg SHALL hold the FSM state type, the frame-length constants (4 data bits) and the NO_CARD=4'd0 constant.
REQ-031 Debounce SHALL be a sub-module named debounce, parameterised by DEB_TICKS and instanced once for car.
REQ-032 Tick-counter width SHALL be clog2(BIT_TICKS).

Verification
REQ-033 Hold car_raw=1 for 8 clocks -> car rises; a 7-clock pulse -> car stays 0.
REQ-034 car=1, frame data 4'b1010, parity 0, stop 1 -> hipass_out=4'hA, one hipass_valid pulse, frame_err=0.
REQ-035 car=1, frame data 4'b0011, parity 1 (odd) -> one frame_err pulse, hipass_out unchanged at 0.
REQ-036 rx low for 3 clocks only (BIT_TICKS=16) -> FSM returns to IDLE, no pulses.
REQ-037 After hipass_out=4'h5, drop car_raw for 8 clocks -> car=0 and hipass_out=0 in the same cycle.
REQ-038 Assert rst during DATA bit 2, then send a valid 4'h9 frame -> only 4'h9 is latched, with exactly one hipass_valid pulse.
